// File: rtl/pc_sequencer_if.sv
// Bundle of request inputs and registered fetch outputs for pc_sequencer.
// Handshake: requests are level-sampled on every rising edge with no ready; one action is taken per edge and lower-priority requests are dropped.
interface pc_sequencer_if #(
   parameter int XLEN      = 32,
   parameter int RAS_DEPTH = 4
);
   localparam int CW = $clog2(RAS_DEPTH) + 1;

   logic            stall;
   logic            trap;
   logic            branch_taken;
   logic [XLEN-1:0] branch_target;
   logic            call_valid;
   logic [XLEN-1:0] call_target;
   logic            ret_valid;
   logic [XLEN-1:0] ret_target;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] pc_plus;
   logic            misaligned;
   logic            ras_underflow;
   logic [CW-1:0]   ras_count;

   modport master (
      output stall, trap, branch_taken, branch_target, call_valid, call_target,
             ret_valid, ret_target,
      input  pc, pc_plus, misaligned, ras_underflow, ras_count
   );

   modport slave (
      input  stall, trap, branch_taken, branch_target, call_valid, call_target,
             ret_valid, ret_target,
      output pc, pc_plus, misaligned, ras_underflow, ras_count
   );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch-stage program-counter sequencer with prioritised redirects.
// Define PC_RAS_EN to build the circular return-address stack; otherwise returns always use ret_target.
module pc_sequencer #(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0040_0000,
   parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0040_0180,
   parameter int              INSTR_BYTES  = 4,
   parameter int              RAS_DEPTH    = 4
) (
   input logic           clk,
   input logic           rst,
   pc_sequencer_if.slave bus
);
   localparam int              CW         = $clog2(RAS_DEPTH) + 1;
   localparam logic [XLEN-1:0] INC        = XLEN'(INSTR_BYTES);
   localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INSTR_BYTES - 1);

   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] next_pc;
   logic [XLEN-1:0] target;
   logic [XLEN-1:0] pc_plus_w;
   logic            redirect;
   logic            push;
   logic            pop;
   logic            mis_n;
   logic            uf_n;
   logic            mis_q;
   logic            uf_q;
   logic            ras_empty;
   logic [XLEN-1:0] ras_top;
   logic [CW-1:0]   ras_cnt;

   assign pc_plus_w = pc_q + INC;

`ifdef PC_RAS_EN
   localparam bit  RAS_ON = 1'b1;
   localparam int  PW     = $clog2(RAS_DEPTH);

   logic [XLEN-1:0] ras_mem [RAS_DEPTH];
   logic [PW-1:0]   ras_ptr;
   logic [PW-1:0]   top_idx;

   // ras_ptr is the next write slot; the newest entry sits one below it.
   assign top_idx   = ras_ptr - PW'(1);
   assign ras_top   = ras_mem[top_idx];
   assign ras_empty = (ras_cnt == '0);

   always_ff @(posedge clk) begin
      if (push) ras_mem[ras_ptr] <= pc_plus_w;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ras_ptr <= '0;
         ras_cnt <= '0;
      end else if (push) begin
         ras_ptr <= ras_ptr + PW'(1);
         if (ras_cnt != CW'(RAS_DEPTH)) ras_cnt <= ras_cnt + CW'(1);
      end else if (pop) begin
         ras_ptr <= top_idx;
         ras_cnt <= ras_cnt - CW'(1);
      end
   end
`else
   localparam bit RAS_ON = 1'b0;

   logic unused_ras;
   assign unused_ras = ^{push, pop, clk};
   assign ras_empty  = 1'b1;
   assign ras_top    = '0;
   assign ras_cnt    = '0;
`endif

   always_comb begin
      next_pc  = pc_plus_w;
      target   = '0;
      redirect = 1'b0;
      push     = 1'b0;
      pop      = 1'b0;
      mis_n    = 1'b0;
      uf_n     = 1'b0;
      if (bus.trap) begin
         next_pc = TRAP_VECTOR;
      end else if (bus.branch_taken) begin
         target   = bus.branch_target;
         redirect = 1'b1;
      end else if (bus.call_valid) begin
         target   = bus.call_target;
         redirect = 1'b1;
         push     = RAS_ON && ((bus.call_target & ALIGN_MASK) == '0);
      end else if (bus.ret_valid) begin
         redirect = 1'b1;
         pop      = RAS_ON && !ras_empty;
         uf_n     = RAS_ON && ras_empty;
         target   = pop ? ras_top : bus.ret_target;
      end else if (bus.stall) begin
         next_pc = pc_q;
      end
      // A misaligned target is never loaded; it is turned into a trap.
      if (redirect) begin
         if ((target & ALIGN_MASK) != '0) begin
            next_pc = TRAP_VECTOR;
            mis_n   = 1'b1;
         end else begin
            next_pc = target;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q  <= RESET_VECTOR;
         mis_q <= 1'b0;
         uf_q  <= 1'b0;
      end else begin
         pc_q  <= next_pc;
         mis_q <= mis_n;
         uf_q  <= uf_n;
      end
   end

   assign bus.pc            = pc_q;
   assign bus.pc_plus       = pc_plus_w;
   assign bus.misaligned    = mis_q;
   assign bus.ras_underflow = uf_q;
   assign bus.ras_count     = ras_cnt;
endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios then random traffic against a queue-based reference model.
// Tracks PC_RAS_EN so the model matches whichever build is compiled.
module tb_pc_sequencer;
   localparam logic [31:0] RV    = 32'h0040_0000;
   localparam logic [31:0] TV    = 32'h0040_0180;
   localparam int          DEPTH = 4;
`ifdef PC_RAS_EN
   localparam bit RAS_ON = 1'b1;
`else
   localparam bit RAS_ON = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   pc_sequencer_if #(.XLEN(32), .RAS_DEPTH(DEPTH)) bus ();

   pc_sequencer #(
      .XLEN(32), .RESET_VECTOR(RV), .TRAP_VECTOR(TV), .INSTR_BYTES(4), .RAS_DEPTH(DEPTH)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int errors = 0;
   int checks = 0;

   logic [31:0] exp_q[$];
   logic [31:0] ras_q[$];
   logic [31:0] m_pc;
   logic        m_mis;
   logic        m_uf;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h at t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic idle();
      rst               = 1'b0;
      bus.stall         = 1'b0;
      bus.trap          = 1'b0;
      bus.branch_taken  = 1'b0;
      bus.branch_target = '0;
      bus.call_valid    = 1'b0;
      bus.call_target   = '0;
      bus.ret_valid     = 1'b0;
      bus.ret_target    = '0;
   endtask

   task automatic go_to(input logic [31:0] t);
      if ((t & 32'h3) != 0) begin
         m_pc  = TV;
         m_mis = 1'b1;
      end else begin
         m_pc = t;
      end
   endtask

   // Reference: one action per edge, chosen by the priority list.
   task automatic model_edge();
      logic [31:0] t;
      m_mis = 1'b0;
      m_uf  = 1'b0;
      if (rst) begin
         m_pc = RV;
         ras_q.delete();
      end else if (bus.trap) begin
         m_pc = TV;
      end else if (bus.branch_taken) begin
         go_to(bus.branch_target);
      end else if (bus.call_valid) begin
         if (RAS_ON && (bus.call_target & 32'h3) == 0) begin
            ras_q.push_back(m_pc + 32'd4);
            if (ras_q.size() > DEPTH) void'(ras_q.pop_front());
         end
         go_to(bus.call_target);
      end else if (bus.ret_valid) begin
         if (ras_q.size() > 0) begin
            t = ras_q.pop_back();
         end else begin
            t    = bus.ret_target;
            m_uf = RAS_ON;
         end
         go_to(t);
      end else if (!bus.stall) begin
         m_pc = m_pc + 32'd4;
      end
   endtask

   task automatic step(input string tag);
      model_edge();
      exp_q.push_back(m_pc);
      @(posedge clk);
      @(negedge clk);
      check({tag, ".pc"}, bus.pc, exp_q.pop_front());
      check({tag, ".pc_plus"}, bus.pc_plus, m_pc + 32'd4);
      check({tag, ".misaligned"}, 32'(bus.misaligned), 32'(m_mis));
      check({tag, ".ras_underflow"}, 32'(bus.ras_underflow), 32'(m_uf));
      check({tag, ".ras_count"}, 32'(bus.ras_count), 32'(ras_q.size()));
   endtask

   logic [31:0] call_tgts [5] = '{32'h0040_1000, 32'h0040_2000, 32'h0040_3000,
                                  32'h0040_4000, 32'h0040_5000};
   logic [31:0] ret_exp   [4] = '{32'h0040_4004, 32'h0040_3004, 32'h0040_2004,
                                  32'h0040_1004};

   function automatic logic [31:0] rand_target();
      logic [31:0] t;
      t = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 9) == 0) t[1:0] = 2'($urandom_range(1, 3));
      return t;
   endfunction

   initial begin
      m_pc  = '0;
      m_mis = 1'b0;
      m_uf  = 1'b0;
      idle();
      @(negedge clk);

      // Reset then free-running fetch.
      rst = 1'b1;
      step("reset");
      check("reset_vector", bus.pc, 32'h0040_0000);
      idle();
      for (int i = 0; i < 4; i++) step("seq");
      check("seq_pc10", bus.pc, 32'h0040_0010);

      // Stall holds, a redirect overrides stall.
      bus.stall = 1'b1;
      step("stall");
      step("stall");
      check("stall_hold", bus.pc, 32'h0040_0010);
      bus.branch_taken  = 1'b1;
      bus.branch_target = 32'h0040_0100;
      step("br_over_stall");
      check("br_over_stall_pc", bus.pc, 32'h0040_0100);
      idle();

      // Trap wins over branch and call, no push.
      bus.branch_taken  = 1'b1;
      bus.branch_target = 32'h0040_0020;
      step("br20");
      idle();
      bus.trap          = 1'b1;
      bus.branch_taken  = 1'b1;
      bus.branch_target = 32'h0040_0300;
      bus.call_valid    = 1'b1;
      bus.call_target   = 32'h0040_0400;
      step("trap_prio");
      check("trap_prio_pc", bus.pc, 32'h0040_0180);
      check("trap_prio_cnt", 32'(bus.ras_count), 32'd0);
      idle();

      // Nested calls past RAS depth, then returns down to underflow.
      rst = 1'b1;
      step("reset2");
      idle();
      for (int i = 0; i < 5; i++) begin
         bus.call_valid  = 1'b1;
         bus.call_target = call_tgts[i];
         step("call");
      end
      check("ras_sat", 32'(bus.ras_count), RAS_ON ? 32'd4 : 32'd0);
      bus.call_valid = 1'b0;
      bus.ret_valid  = 1'b1;
      bus.ret_target = 32'h0;
      for (int i = 0; i < 5; i++) begin
         step("ret");
         if (RAS_ON && i < 4) check("ret_pop", bus.pc, ret_exp[i]);
      end
      check("ret_final_pc", bus.pc, 32'h0);
      check("ret_uf_pulse", 32'(bus.ras_underflow), 32'(RAS_ON));
      idle();
      step("after_uf");
      check("uf_drop", 32'(bus.ras_underflow), 32'd0);

      // Misaligned branch becomes a trap with a one-cycle flag.
      bus.branch_taken  = 1'b1;
      bus.branch_target = 32'h0040_0102;
      step("mis_br");
      check("mis_pc", bus.pc, 32'h0040_0180);
      check("mis_hi", 32'(bus.misaligned), 32'd1);
      idle();
      step("mis_after");
      check("mis_lo", 32'(bus.misaligned), 32'd0);

      // Wrap at top of address space; reset beats a pending call.
      bus.call_valid  = 1'b1;
      bus.call_target = 32'hFFFF_FFFC;
      step("call_top");
      idle();
      step("wrap");
      check("wrap_pc", bus.pc, 32'h0);
      rst             = 1'b1;
      bus.call_valid  = 1'b1;
      bus.call_target = 32'h0040_0800;
      step("rst_over_call");
      check("rst_over_call_pc", bus.pc, 32'h0040_0000);
      check("rst_over_call_cnt", 32'(bus.ras_count), 32'd0);
      idle();

      // Random traffic.
      for (int n = 0; n < 3000; n++) begin
         rst               = ($urandom_range(0, 99) == 0);
         bus.trap          = ($urandom_range(0, 19) == 0);
         bus.branch_taken  = ($urandom_range(0, 7) == 0);
         bus.branch_target = rand_target();
         bus.call_valid    = ($urandom_range(0, 5) == 0);
         bus.call_target   = rand_target();
         bus.ret_valid     = ($urandom_range(0, 5) == 0);
         bus.ret_target    = rand_target();
         bus.stall         = ($urandom_range(0, 3) == 0);
         step("rand");
      end
      idle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
